// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, owner tags
// and the width of the data-streak counter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int STREAK_W = 4;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the load/store
// port, one transaction at a time, with a streak limit that keeps fetch from starving.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                if_err,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_err,
  output logic                d_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          fsm_state,
  output logic [STREAK_W-1:0] streak_count
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  state_t              state;
  owner_t              owner;
  logic [STREAK_W-1:0] streak;

  logic                grant_d;
  logic                grant_any;
  logic                misaligned;
  logic                resp_done;
  logic [ADDR_W-1:0]   sel_addr;
  logic [STREAK_W-1:0] streak_next;

  // Data normally wins; a waiting fetch is forced through once the streak is full.
  always_comb begin
    grant_d     = d_req && !(if_req && (streak == STREAK_MAX));
    grant_any   = d_req || if_req;
    sel_addr    = grant_d ? d_addr : if_addr;
    misaligned  = is_misaligned(sel_addr[1:0]);
    streak_next = '0;
    if (grant_d && if_req)
      streak_next = (streak == STREAK_MAX) ? streak : streak + STREAK_ONE;
    resp_done   = ((state == ST_REQ) && mem_gnt && mem_rvalid) ||
                  ((state == ST_WAIT) && mem_rvalid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner  <= grant_d ? OWN_D : OWN_IF;
            streak <= streak_next;
            if (misaligned) begin
              state <= ST_DONE;
              if (grant_d) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                if_ack   <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end
            end else begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= grant_d && d_we;
              mem_addr  <= {sel_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= grant_d ? d_wdata : '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= mem_rvalid ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Stores complete without touching the returned data register.
      if (resp_done) begin
        if (owner == OWN_D) begin
          d_ack <= 1'b1;
          d_err <= 1'b0;
          if (!mem_we) d_rdata <= mem_rdata;
        end else begin
          if_ack   <= 1'b1;
          if_err   <= 1'b0;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign if_stall     = if_req & ~if_ack;
  assign d_stall      = d_req & ~d_ack;
  assign fsm_state    = state;
  assign streak_count = streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// model of arbitration order, streak limit and memory contents.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic          clk;
  logic          reset;
  logic          if_req, if_ack, if_err, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_ack, d_err, d_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    fsm_state;
  logic [3:0]    streak_count;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [31:0] mem_arr[16];
  logic [31:0] shadow[16];
  logic        mem_auto;
  logic [31:0] seen_addr, seen_wdata;
  logic        seen_we;
  logic        pend_if, pend_d;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .if_err(if_err), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state), .streak_count(streak_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("if_stall", 32'(if_stall), 32'(if_req & ~if_ack));
    check("d_stall", 32'(d_stall), 32'(d_req & ~d_ack));
  endtask

  // Memory side: waits for a request, holds gnt off for gd cycles, returns
  // rvalid rd cycles after gnt (rd=0 means same cycle). Stray rvalids are
  // sprinkled where the arbiter must ignore them.
  task automatic mem_serve(input int gd, input int rd, input logic [31:0] data);
    int n;
    logic [31:0] rsp;
    n = 0;
    rsp = data;
    while (!mem_req && n < 10) begin
      mem_rvalid = ($urandom_range(0, 3) == 0);
      mem_rdata  = $urandom;
      tick();
      n++;
    end
    mem_rvalid = 1'b0;
    check("mem_req_seen", 32'(mem_req), 32'd1);
    if (mem_req) begin
      repeat (gd) begin
        mem_rvalid = ($urandom_range(0, 2) == 0);
        mem_rdata  = $urandom;
        tick();
      end
      seen_addr  = mem_addr;
      seen_we    = mem_we;
      seen_wdata = mem_wdata;
      if (mem_auto) begin
        if (mem_we) mem_arr[mem_addr[5:2]] = mem_wdata;
        rsp = mem_arr[mem_addr[5:2]];
      end
      mem_gnt    = 1'b1;
      mem_rvalid = (rd == 0);
      mem_rdata  = rsp;
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rd > 0) begin
        repeat (rd - 1) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = rsp;
        tick();
        mem_rvalid = 1'b0;
      end
    end
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(if_ack || d_ack) && n < 8);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = rand_addr();
    pend_if = 1'b1;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_addr  = rand_addr();
    d_we    = 1'($urandom_range(0, 1));
    d_wdata = $urandom;
    pend_d  = 1'b1;
  endtask

  initial begin
    logic        win_d, mis, exp_if;
    logic [31:0] a, exp_rd, last_d_rdata;
    logic [33:0] e;
    int          streak_m, sel, dn;

    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_auto = 0;
    seen_addr = 0; seen_wdata = 0; seen_we = 0; pend_if = 0; pend_d = 0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_acks", 32'({if_ack, if_err, d_ack, d_err}), 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_streak", 32'(streak_count), 0);
    reset = 1'b0;
    tick();

    // Single load: gnt one cycle after request, rvalid two cycles after gnt
    d_req = 1; d_addr = 32'h10; d_we = 0;
    tick();
    check("ld_mem_req", 32'(mem_req), 1);
    check("ld_mem_addr", mem_addr, 32'h10);
    check("ld_mem_we", 32'(mem_we), 0);
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    check("ld_req_drop", 32'(mem_req), 0);
    tick();
    check("ld_no_early_ack", 32'(d_ack), 0);
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 0;
    check("ld_ack", 32'(d_ack), 1);
    check("ld_rdata", d_rdata, 32'hDEADBEEF);
    check("ld_err", 32'(d_err), 0);
    check("ld_if_ack", 32'(if_ack), 0);
    d_req = 0;
    tick();
    check("ld_ack_pulse", 32'(d_ack), 0);

    // Simultaneous requests: data first, then fetch
    if_req = 1; if_addr = 32'h40; d_req = 1; d_addr = 32'h44; d_we = 0;
    mem_serve(0, 0, 32'hA1);
    check("sim_d_ack", 32'(d_ack), 1);
    check("sim_if_ack0", 32'(if_ack), 0);
    check("sim_d_rdata", d_rdata, 32'hA1);
    check("sim_d_addr", seen_addr, 32'h44);
    check("sim_if_stall", 32'(if_stall), 1);
    d_req = 0;
    mem_serve(1, 1, 32'hB2);
    check("sim_if_ack", 32'(if_ack), 1);
    check("sim_d_ack0", 32'(d_ack), 0);
    check("sim_if_rdata", if_rdata, 32'hB2);
    check("sim_if_addr", seen_addr, 32'h40);
    check("sim_if_we", 32'(seen_we), 0);
    if_req = 0;

    // Starvation guard: four data grants, then the held fetch
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h100;
    dn = 0;
    for (int k = 0; k < 6; k++) begin
      mem_serve(0, 0, 32'h5000 + 32'(k));
      exp_if = (k == 4);
      check("sv_if_ack", 32'(if_ack), 32'(exp_if));
      check("sv_d_ack", 32'(d_ack), 32'(!exp_if));
      check("sv_rdata", exp_if ? if_rdata : d_rdata, 32'h5000 + 32'(k));
      check("sv_streak", 32'(streak_count), (k < 4) ? 32'(k + 1) : 32'd0);
      if (exp_if) if_req = 0;
      else begin
        dn++;
        d_addr = 32'h100 + 32'(4 * dn);
      end
    end
    d_req = 0;

    // Store leaves d_rdata untouched
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    mem_serve(1, 2, 32'hFFFF0000);
    check("st_mem_we", 32'(seen_we), 1);
    check("st_mem_wdata", seen_wdata, 32'h12345678);
    check("st_mem_addr", seen_addr, 32'h20);
    check("st_ack", 32'(d_ack), 1);
    check("st_err", 32'(d_err), 0);
    check("st_rdata_kept", d_rdata, 32'h5005);
    d_req = 0; d_we = 0;

    // Misaligned fetch never reaches memory
    if_req = 1; if_addr = 32'h6;
    tick();
    check("mis_no_early_ack", 32'(if_ack), 0);
    check("mis_mem_req_a", 32'(mem_req), 0);
    tick();
    check("mis_ack", 32'(if_ack), 1);
    check("mis_err", 32'(if_err), 1);
    check("mis_rdata", if_rdata, 0);
    check("mis_mem_req_b", 32'(mem_req), 0);
    if_req = 0;
    tick();
    check("mis_ack_pulse", 32'(if_ack), 0);
    check("mis_mem_req_c", 32'(mem_req), 0);

    // Reset while waiting for the response; late rvalid must be dropped
    d_req = 1; d_we = 0; d_addr = 32'h30;
    tick();
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    check("rw_in_wait", 32'(fsm_state), 32'(ST_WAIT));
    reset = 1; d_req = 0;
    tick();
    reset = 0;
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    tick();
    mem_rvalid = 0;
    check("rw_no_d_ack", 32'(d_ack), 0);
    check("rw_no_if_ack", 32'(if_ack), 0);
    check("rw_idle", 32'(fsm_state), 32'(ST_IDLE));
    check("rw_mem_req", 32'(mem_req), 0);
    tick();
    check("rw_no_d_ack2", 32'(d_ack), 0);
    d_req = 1;
    mem_serve(0, 1, 32'h600D);
    check("rw_retry_ack", 32'(d_ack), 1);
    check("rw_retry_rdata", d_rdata, 32'h600D);
    d_req = 0;

    // Randomized traffic against the transaction-level model
    reset = 1;
    tick();
    reset = 0;
    mem_auto = 1;
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = $urandom;
      shadow[i]  = mem_arr[i];
    end
    streak_m = 0;
    last_d_rdata = 0;
    for (int t = 0; t < 150; t++) begin
      if (!pend_if && !pend_d) begin
        sel = $urandom_range(1, 3);
        if (sel[0]) new_if();
        if (sel[1]) new_d();
      end
      win_d = pend_d && !(pend_if && streak_m == MAXS);
      if (win_d && pend_if) streak_m = (streak_m < MAXS) ? streak_m + 1 : streak_m;
      else streak_m = 0;
      a = win_d ? d_addr : if_addr;
      mis = (a[1:0] != 2'b00);
      if (mis) exp_rd = 0;
      else if (win_d && d_we) exp_rd = last_d_rdata;
      else exp_rd = shadow[a[5:2]];
      exp_q.push_back({win_d, mis, exp_rd});

      if (mis) wait_ack();
      else mem_serve($urandom_range(0, 2), $urandom_range(0, 2), 32'h0);

      e = exp_q.pop_front();
      check("rnd_d_ack", 32'(d_ack), 32'(e[33]));
      check("rnd_if_ack", 32'(if_ack), 32'(!e[33]));
      check("rnd_err", 32'(e[33] ? d_err : if_err), 32'(e[32]));
      check("rnd_rdata", e[33] ? d_rdata : if_rdata, e[31:0]);
      check("rnd_streak", 32'(streak_count), 32'(streak_m));
      if (!mis) begin
        check("rnd_mem_addr", seen_addr, {a[31:2], 2'b00});
        check("rnd_mem_we", 32'(seen_we), 32'(win_d && d_we));
        if (win_d && d_we) check("rnd_mem_wdata", seen_wdata, d_wdata);
      end
      if (win_d && d_we && !mis) shadow[a[5:2]] = d_wdata;
      if (win_d && !(d_we && !mis)) last_d_rdata = exp_rd;

      if (win_d) begin
        pend_d = 0; d_req = 0;
        if ($urandom_range(0, 1) == 1) new_d();
      end else begin
        pend_if = 0; if_req = 0;
        if ($urandom_range(0, 1) == 1) new_if();
      end
      tick();
      check("rnd_ack_pulse", 32'({if_ack, d_ack}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
